tcp_session_tracker: RTL and testbench

// - Consumes the per-packet TCP classification FIFO output of the flag-check stage.
// - Tracks one TCP session in an FSM: CLOSED, ESTABLISHED, LAST_ACK.
// - Emits one reply descriptor per packet that needs an answer (ACK or FIN_ACK), carrying seq/ack/timestamp fields.
// - The downstream reply-packet builder consumes the descriptor on a valid/ready handshake.

---
 rtl/tcp_session_pkg.sv | 22 ++
 rtl/tcp_ts_clock.sv | 37 +++
 rtl/tcp_session_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_tcp_session_tracker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_session_pkg.sv
// Shared types and helpers for the TCP session tracker.
package tcp_session_pkg;

    localparam int SESSION_STATE_W = 2;

    typedef enum logic [SESSION_STATE_W-1:0] {
        ST_CLOSED   = 2'd0,
        ST_EST      = 2'd1,
        ST_LAST_ACK = 2'd2
    } session_state_e;

    typedef enum logic [1:0] {
        RPL_NONE    = 2'd0,
        RPL_ACK     = 2'd1,
        RPL_FIN_ACK = 2'd2
    } reply_type_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/tcp_ts_clock.sv
// Local TSval source: prescaler of TS_DIV cycles feeding a free-running 32-bit tick counter.
module tcp_ts_clock #(
    parameter int unsigned TS_DIV = 200
) (
    input  logic        axis_aclk,
    input  logic        axis_resetn,
    output logic [31:0] tsval
);

    localparam int unsigned PRE_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TS_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [31:0]      tsval_q, tsval_d;

    always_comb begin
        pre_d   = pre_q + PRE_W'(1);
        tsval_d = tsval_q;
        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            tsval_d = tsval_q + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            pre_q   <= '0;
            tsval_q <= '0;
        end else begin
            pre_q   <= pre_d;
            tsval_q <= tsval_d;
        end
    end

    always_comb tsval = tsval_q;

endmodule

// File: rtl/tcp_session_tracker.sv
// Single-session TCP tracker: pops classified packets, walks CLOSED/ESTABLISHED/LAST_ACK,
// and emits registered ACK/FIN_ACK reply descriptors. Optional counters: TCP_SESSION_STATS_EN.
module tcp_session_tracker
    import tcp_session_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 2**24,
    parameter int unsigned TMR_WIDTH    = 25,
    parameter int unsigned TS_DIV       = 200
) (
    input  logic                       axis_aclk,
    input  logic                       axis_resetn,
    input  logic                       hand_shake_vld,
    input  logic                       is_tcp,
    input  logic                       is_tcp_hand_shake,
    input  logic                       is_tcp_ack,
    input  logic                       is_tcp_fin,
    input  logic [31:0]                seq_value,
    input  logic [31:0]                ack_value,
    input  logic [31:0]                ts_val,
    input  logic [31:0]                ecr_val,
    output logic                       rd_check,
    output logic                       reply_vld,
    input  logic                       reply_rdy,
    output logic [1:0]                 reply_type,
    output logic [31:0]                reply_seq,
    output logic [31:0]                reply_ack,
    output logic [31:0]                reply_tsval,
    output logic [31:0]                reply_tsecr,
    output logic [SESSION_STATE_W-1:0] session_state
`ifdef TCP_SESSION_STATS_EN
    ,
    output logic [31:0]                stat_est,
    output logic [31:0]                stat_fin,
    output logic [31:0]                stat_drop,
    output logic [31:0]                stat_stall
`endif
);

    localparam bit TMR_EN = (IDLE_TIMEOUT != 0);
    localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);

    session_state_e       state_q, state_d;
    logic [TMR_WIDTH-1:0] timer_q, timer_d;
    logic [31:0]          fin_seq_q, fin_seq_d;
    logic                 reply_vld_q, reply_vld_d;
    reply_type_e          reply_type_q, reply_type_d;
    logic [31:0]          reply_seq_q, reply_seq_d;
    logic [31:0]          reply_ack_q, reply_ack_d;
    logic [31:0]          reply_tsval_q, reply_tsval_d;
    logic [31:0]          reply_tsecr_q, reply_tsecr_d;
    logic [31:0]          tsval;

    logic        pop, is_hs, is_fin, is_ack, is_data, fin_close, expire;
    logic        load, fin_latch;
    reply_type_e load_type;

    tcp_ts_clock #(.TS_DIV(TS_DIV)) u_ts_clock (
        .axis_aclk   (axis_aclk),
        .axis_resetn (axis_resetn),
        .tsval       (tsval)
    );

    // Flag priority when several are set: SYN+ACK, then FIN, then ACK.
    always_comb begin
        pop       = axis_resetn & hand_shake_vld & (~reply_vld_q | reply_rdy);
        is_hs     = is_tcp & is_tcp_hand_shake;
        is_fin    = is_tcp & ~is_tcp_hand_shake & is_tcp_fin;
        is_ack    = is_tcp & ~is_tcp_hand_shake & ~is_tcp_fin & is_tcp_ack;
        is_data   = is_tcp & ~is_tcp_hand_shake & ~is_tcp_fin & ~is_tcp_ack;
        fin_close = is_ack & (ack_value == fin_seq_q + 32'd1);
        expire    = TMR_EN & (state_q != ST_CLOSED) & (timer_q == TMR_LAST);
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) state_q <= ST_CLOSED;
        else              state_q <= state_d;
    end

    // A pop always takes precedence over idle expiry.
    always_comb begin
        state_d = state_q;
        if (pop) begin
            case (state_q)
                ST_CLOSED:   if (is_hs)     state_d = ST_EST;
                ST_EST:      if (is_fin)    state_d = ST_LAST_ACK;
                ST_LAST_ACK: if (fin_close) state_d = ST_CLOSED;
                default:                    state_d = ST_CLOSED;
            endcase
        end else if (expire) begin
            state_d = ST_CLOSED;
        end
    end

    always_comb begin
        load      = 1'b0;
        load_type = RPL_ACK;
        fin_latch = 1'b0;
        if (pop) begin
            case (state_q)
                ST_CLOSED: load = is_hs;
                ST_EST: begin
                    if (is_hs || is_data) begin
                        load = 1'b1;
                    end else if (is_fin) begin
                        load      = 1'b1;
                        load_type = RPL_FIN_ACK;
                        fin_latch = 1'b1;
                    end
                end
                ST_LAST_ACK: begin
                    if (is_fin) begin
                        load      = 1'b1;
                        load_type = RPL_FIN_ACK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reply_vld_d   = reply_vld_q & ~reply_rdy;
        reply_type_d  = reply_type_q;
        reply_seq_d   = reply_seq_q;
        reply_ack_d   = reply_ack_q;
        reply_tsval_d = reply_tsval_q;
        reply_tsecr_d = reply_tsecr_q;
        if (load) begin
            reply_vld_d   = 1'b1;
            reply_type_d  = load_type;
            reply_seq_d   = ack_value;
            reply_ack_d   = seq_value;
            reply_tsval_d = tsval;
            reply_tsecr_d = ts_val;
        end
        fin_seq_d = fin_latch ? ack_value : fin_seq_q;
        if (!TMR_EN || pop || expire || (state_q == ST_CLOSED)) timer_d = '0;
        else                                                    timer_d = timer_q + TMR_WIDTH'(1);
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            timer_q       <= '0;
            fin_seq_q     <= '0;
            reply_vld_q   <= 1'b0;
            reply_type_q  <= RPL_NONE;
            reply_seq_q   <= '0;
            reply_ack_q   <= '0;
            reply_tsval_q <= '0;
            reply_tsecr_q <= '0;
        end else begin
            timer_q       <= timer_d;
            fin_seq_q     <= fin_seq_d;
            reply_vld_q   <= reply_vld_d;
            reply_type_q  <= reply_type_d;
            reply_seq_q   <= reply_seq_d;
            reply_ack_q   <= reply_ack_d;
            reply_tsval_q <= reply_tsval_d;
            reply_tsecr_q <= reply_tsecr_d;
        end
    end

    always_comb begin
        rd_check      = pop;
        reply_vld     = reply_vld_q;
        reply_type    = reply_type_q;
        reply_seq     = reply_seq_q;
        reply_ack     = reply_ack_q;
        reply_tsval   = reply_tsval_q;
        reply_tsecr   = reply_tsecr_q;
        session_state = state_q;
    end

`ifdef TCP_SESSION_STATS_EN
    logic [31:0] stat_est_q, stat_est_d;
    logic [31:0] stat_fin_q, stat_fin_d;
    logic [31:0] stat_drop_q, stat_drop_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Pure ACKs in ESTABLISHED are normal traffic, not drops.
    always_comb begin
        stat_est_d   = sat_inc(stat_est_q, pop & (state_q == ST_CLOSED) & (state_d == ST_EST));
        stat_fin_d   = sat_inc(stat_fin_q, load & (load_type == RPL_FIN_ACK));
        stat_drop_d  = sat_inc(stat_drop_q, pop & ~load & (state_d == state_q)
                                            & ~((state_q == ST_EST) & is_ack));
        stat_stall_d = sat_inc(stat_stall_q, reply_vld_q & ~reply_rdy);
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            stat_est_q   <= '0;
            stat_fin_q   <= '0;
            stat_drop_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_est_q   <= stat_est_d;
            stat_fin_q   <= stat_fin_d;
            stat_drop_q  <= stat_drop_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    always_comb begin
        stat_est   = stat_est_q;
        stat_fin   = stat_fin_q;
        stat_drop  = stat_drop_q;
        stat_stall = stat_stall_q;
    end
`else
    logic unused_ecr;
    always_comb unused_ecr = ^ecr_val;
`endif

endmodule

// File: tb/tb_tcp_session_tracker.sv
// Scoreboard bench for tcp_session_tracker: FIFO model feeds entries, expected replies are checked on accept.
module tb_tcp_session_tracker;

    localparam int unsigned TS_DIV = 4;
    localparam int unsigned IDLE   = 16;

    logic        clk = 1'b0;
    logic        axis_resetn = 1'b0;
    logic        hand_shake_vld = 1'b0;
    logic        is_tcp = 1'b0, is_tcp_hand_shake = 1'b0, is_tcp_ack = 1'b0, is_tcp_fin = 1'b0;
    logic [31:0] seq_value = '0, ack_value = '0, ts_val = '0, ecr_val = '0;
    logic        rd_check, reply_vld;
    logic        reply_rdy = 1'b1;
    logic [1:0]  reply_type;
    logic [31:0] reply_seq, reply_ack, reply_tsval, reply_tsecr;
    logic [1:0]  session_state;
`ifdef TCP_SESSION_STATS_EN
    logic [31:0] stat_est, stat_fin, stat_drop, stat_stall;
`endif

    always #5 clk = ~clk;

    tcp_session_tracker #(
        .IDLE_TIMEOUT (IDLE),
        .TMR_WIDTH    (8),
        .TS_DIV       (TS_DIV)
    ) dut (
        .axis_aclk         (clk),
        .axis_resetn       (axis_resetn),
        .hand_shake_vld    (hand_shake_vld),
        .is_tcp            (is_tcp),
        .is_tcp_hand_shake (is_tcp_hand_shake),
        .is_tcp_ack        (is_tcp_ack),
        .is_tcp_fin        (is_tcp_fin),
        .seq_value         (seq_value),
        .ack_value         (ack_value),
        .ts_val            (ts_val),
        .ecr_val           (ecr_val),
        .rd_check          (rd_check),
        .reply_vld         (reply_vld),
        .reply_rdy         (reply_rdy),
        .reply_type        (reply_type),
        .reply_seq         (reply_seq),
        .reply_ack         (reply_ack),
        .reply_tsval       (reply_tsval),
        .reply_tsecr       (reply_tsecr),
        .session_state     (session_state)
`ifdef TCP_SESSION_STATS_EN
        ,
        .stat_est          (stat_est),
        .stat_fin          (stat_fin),
        .stat_drop         (stat_drop),
        .stat_stall        (stat_stall)
`endif
    );

    typedef struct {
        logic        tcp, hs, ack, fin;
        logic [31:0] seq, ackv, ts;
        logic [1:0]  rtype;
    } ent_t;

    typedef struct {
        logic [1:0]  rtype;
        logic [31:0] seq, ack, tsval, tsecr;
    } rep_t;

    ent_t        in_q[$];
    rep_t        exp_q[$];
    ent_t        mon_e;
    rep_t        mon_r, got_r;
    logic        do_pop = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Non-reset edges since the last reset edge; local TSval model is cyc / TS_DIV.
    always @(posedge clk) cyc <= axis_resetn ? cyc + 1 : 0;

    always @(negedge clk) begin
        do_pop = 1'b0;
        if (axis_resetn && rd_check && in_q.size() != 0) begin
            mon_e  = in_q[0];
            do_pop = 1'b1;
            if (mon_e.rtype != 2'd0) begin
                mon_r.rtype = mon_e.rtype;
                mon_r.seq   = mon_e.ackv;
                mon_r.ack   = mon_e.seq;
                mon_r.tsval = cyc / TS_DIV;
                mon_r.tsecr = mon_e.ts;
                exp_q.push_back(mon_r);
            end
        end
        if (axis_resetn && reply_vld && reply_rdy) begin
            check_eq("reply_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                got_r = exp_q.pop_front();
                check_eq("rpl_type",  reply_type,  got_r.rtype);
                check_eq("rpl_seq",   reply_seq,   got_r.seq);
                check_eq("rpl_ack",   reply_ack,   got_r.ack);
                check_eq("rpl_tsval", reply_tsval, got_r.tsval);
                check_eq("rpl_tsecr", reply_tsecr, got_r.tsecr);
            end
        end
    end

    // Fall-through FIFO model: the head is presented until the DUT pops it.
    always @(posedge clk) begin
        #1;
        if (do_pop && in_q.size() != 0) in_q.delete(0);
        if (in_q.size() != 0) begin
            hand_shake_vld    = 1'b1;
            is_tcp            = in_q[0].tcp;
            is_tcp_hand_shake = in_q[0].hs;
            is_tcp_ack        = in_q[0].ack;
            is_tcp_fin        = in_q[0].fin;
            seq_value         = in_q[0].seq;
            ack_value         = in_q[0].ackv;
            ts_val            = in_q[0].ts;
            ecr_val           = ~in_q[0].ts;
        end else begin
            hand_shake_vld    = 1'b0;
            is_tcp            = 1'b0;
            is_tcp_hand_shake = 1'b0;
            is_tcp_ack        = 1'b0;
            is_tcp_fin        = 1'b0;
        end
    end

    task automatic push(input logic tcp, input logic hs, input logic ack, input logic fin,
                        input logic [31:0] seq, input logic [31:0] ackv, input logic [31:0] ts,
                        input logic [1:0] rtype);
        ent_t e;
        e.tcp = tcp; e.hs = hs; e.ack = ack; e.fin = fin;
        e.seq = seq; e.ackv = ackv; e.ts = ts; e.rtype = rtype;
        in_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((in_q.size() != 0 || exp_q.size() != 0 || reply_vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n < 200, 1'b1);
    endtask

    task automatic wait_pop(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_check && n < 100);
        check_eq(tag, n < 100, 1'b1);
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!reply_vld && n < 100);
        check_eq(tag, n < 100, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        push(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h20, 32'h30, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rd_check",  rd_check,      1'b0);
        check_eq("rst_reply_vld", reply_vld,     1'b0);
        check_eq("rst_type",      reply_type,    2'd0);
        check_eq("rst_seq",       reply_seq,     32'h0);
        check_eq("rst_ack",       reply_ack,     32'h0);
        check_eq("rst_tsval",     reply_tsval,   32'h0);
        check_eq("rst_state",     session_state, 2'd0);
        @(posedge clk);
        #1 axis_resetn = 1'b1;

        // Non-TCP and a pure ACK in CLOSED are dropped.
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 32'h33, 2'd0);
        wait_idle("idle_drop");
        check_eq("drop_state", session_state, 2'd0);
`ifdef TCP_SESSION_STATS_EN
        check_eq("stat_drop_2", stat_drop, 32'd2);
`endif

        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h1001, 32'h5000, 32'hAA, 2'd1);
        wait_pop("pop_synack");
        @(negedge clk);
        check_eq("synack_vld_n1",  reply_vld,     1'b1);
        check_eq("synack_type_n1", reply_type,    2'd1);
        check_eq("synack_state",   session_state, 2'd1);
        wait_idle("idle_synack");

        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h1100, 32'h5000, 32'hBB, 2'd1);
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h1100, 32'h5000, 32'hBC, 2'd0);
        wait_idle("idle_data");
        check_eq("est_state", session_state, 2'd1);

        // Backpressure: one reply held, three entries waiting.
        @(posedge clk);
        #1 reply_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000 + i, 32'h5000, 32'hD0 + i, 2'd1);
        wait_vld("stall_vld");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_rd_check", rd_check,  1'b0);
            check_eq("stall_vld_hold", reply_vld, 1'b1);
            check_eq("stall_ack_hold", reply_ack, 32'h3000);
            check_eq("stall_seq_hold", reply_seq, 32'h5000);
        end
        @(posedge clk);
        #1 reply_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("burst_vld", reply_vld, 1'b1);
        end
        wait_idle("idle_stall");

        push(1'b1, 1'b0, 1'b0, 1'b1, 32'h2001, 32'h6000, 32'hCC, 2'd2);
        wait_idle("idle_fin");
        check_eq("fin_state", session_state, 2'd2);
        push(1'b1, 1'b0, 1'b0, 1'b1, 32'h2001, 32'h6000, 32'hCD, 2'd2);
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h2001, 32'h6005, 32'hCE, 2'd0);
        wait_idle("idle_lastack");
        check_eq("lastack_state", session_state, 2'd2);
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h2001, 32'h6001, 32'hCF, 2'd0);
        wait_idle("idle_close");
        check_eq("closed_state", session_state, 2'd0);
`ifdef TCP_SESSION_STATS_EN
        check_eq("stat_est",   stat_est,   32'd1);
        check_eq("stat_fin",   stat_fin,   32'd2);
        check_eq("stat_drop3", stat_drop,  32'd3);
        check_eq("stat_stall", stat_stall, 32'd6);
`endif

        // Idle expiry exactly IDLE edges after the last pop.
        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h7001, 32'h8000, 32'h11, 2'd1);
        wait_pop("pop_to1");
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) check_eq("to_state_pre",  session_state, 2'd1);
            if (k == 17) check_eq("to_state_post", session_state, 2'd0);
        end

        // A pop on the expiry cycle keeps the session alive.
        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h7101, 32'h8100, 32'h12, 2'd1);
        wait_pop("pop_to2");
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 15) push(1'b1, 1'b0, 1'b1, 1'b0, 32'h7101, 32'h8100, 32'h13, 2'd0);
            if (k == 16) check_eq("to_pop_at16",  rd_check,      1'b1);
            if (k == 17) check_eq("to_kept",      session_state, 2'd1);
            if (k == 32) check_eq("to2_pre",      session_state, 2'd1);
            if (k == 33) check_eq("to2_post",     session_state, 2'd0);
        end

        // Reset while a reply is pending.
        @(posedge clk);
        #1 reply_rdy = 1'b0;
        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h9001, 32'hA000, 32'h22, 2'd1);
        wait_vld("rst_pending_vld");
        @(posedge clk);
        #1 axis_resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 axis_resetn = 1'b1;
        reply_rdy = 1'b1;
        @(negedge clk);
        check_eq("midrst_vld",   reply_vld,     1'b0);
        check_eq("midrst_state", session_state, 2'd0);
        check_eq("midrst_type",  reply_type,    2'd0);
`ifdef TCP_SESSION_STATS_EN
        check_eq("midrst_stat_est",   stat_est,   32'd0);
        check_eq("midrst_stat_stall", stat_stall, 32'd0);
`endif
        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h9101, 32'hA100, 32'h33, 2'd1);
        wait_pop("pop_after_rst");
        @(negedge clk);
        check_eq("tsval_after_rst", reply_tsval, 32'h0);
        wait_idle("idle_end");

        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
